// File: rtl/half_adder.sv
// Half adder with a combinational sum/carry path and a registered, valid-qualified
// copy of the result. Optional statistics counters (accepted pairs and pairs that
// produced a carry) are compiled in when the macro HALF_ADDER_STATS_EN is defined.
module half_adder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             in_valid,
    output logic             sum,
    output logic             carry,
    output logic             sum_q,
    output logic             carry_q,
    output logic             out_valid
`ifdef HALF_ADDER_STATS_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] op_cnt,
    output logic [CNT_W-1:0] carry_cnt
`endif
);

    // Counter width must fit the 1..32 range the counters were designed for.
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("half_adder: CNT_W out of range 1..32");
    end

    // Zero-latency path; deliberately independent of clk, rst_n and in_valid.
    assign sum   = a ^ b;
    assign carry = a & b;

    // Capture the result of each accepted pair; hold it when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= 1'b0;
            carry_q   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q   <= a ^ b;
                carry_q <= a & b;
            end
        end
    end

`ifdef HALF_ADDER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Saturating statistics counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt    <= '0;
            carry_cnt <= '0;
        end else if (cnt_clr) begin
            op_cnt    <= '0;
            carry_cnt <= '0;
        end else if (in_valid) begin
            if (op_cnt != CNT_MAX) begin
                op_cnt <= op_cnt + CNT_ONE;
            end
            if (a && b && (carry_cnt != CNT_MAX)) begin
                carry_cnt <= carry_cnt + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder. Expected registered results are pushed to a
// scoreboard queue when an operand pair is driven and popped when out_valid shows
// up one clock later. Statistics checks are compiled when HALF_ADDER_STATS_EN is set.
module tb_half_adder;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          clk_en = 1'b0;
    logic          rst_n = 1'b1;
    logic          a = 1'b0;
    logic          b = 1'b0;
    logic          in_valid = 1'b0;
    logic          sum;
    logic          carry;
    logic          sum_q;
    logic          carry_q;
    logic          out_valid;
`ifdef HALF_ADDER_STATS_EN
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] op_cnt;
    logic [CW-1:0] carry_cnt;
    int            exp_op = 0;
    int            exp_cr = 0;
`endif

    int   checks = 0;
    int   errors = 0;
    logic [1:0] sb_q[$];        // {sum, carry} expected per accepted pair
    logic       last_sum = 1'b0;
    logic       last_carry = 1'b0;
    logic       cur_valid = 1'b0;

    half_adder #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .sum       (sum),
        .carry     (carry),
        .sum_q     (sum_q),
        .carry_q   (carry_q),
        .out_valid (out_valid)
`ifdef HALF_ADDER_STATS_EN
        ,
        .cnt_clr   (cnt_clr),
        .op_cnt    (op_cnt),
        .carry_cnt (carry_cnt)
`endif
    );

    // Clock runs only while clk_en is set, so the combinational path can be tested idle.
    always #5 clk = clk_en ? ~clk : 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Apply one operand pair, check the combinational outputs, queue the expected result.
    task automatic drive(input logic av, input logic bv, input logic v);
        a = av;
        b = bv;
        in_valid = v;
        cur_valid = v;
        if (v) sb_q.push_back({av ^ bv, av & bv});
        #1;
        check("comb_sum", {31'd0, sum}, {31'd0, av ^ bv});
        check("comb_carry", {31'd0, carry}, {31'd0, av & bv});
    endtask

    // Let one rising edge pass, then compare registered outputs against the scoreboard.
    task automatic settle();
        logic [1:0] e;
        @(posedge clk);
`ifdef HALF_ADDER_STATS_EN
        if (cnt_clr) begin
            exp_op = 0;
            exp_cr = 0;
        end else if (cur_valid) begin
            if (exp_op < 3) exp_op++;
            if (a && b && exp_cr < 3) exp_cr++;
        end
`endif
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, cur_valid});
        if (cur_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                last_sum = e[1];
                last_carry = e[0];
            end
        end
        check("sum_q", {31'd0, sum_q}, {31'd0, last_sum});
        check("carry_q", {31'd0, carry_q}, {31'd0, last_carry});
        check("not_both", {31'd0, sum_q & carry_q}, 32'd0);
`ifdef HALF_ADDER_STATS_EN
        check("op_cnt", {30'd0, op_cnt}, exp_op);
        check("carry_cnt", {30'd0, carry_cnt}, exp_cr);
`endif
    endtask

    task automatic step(input logic av, input logic bv, input logic v);
        drive(av, bv, v);
        settle();
    endtask

    task automatic reset_model();
        sb_q.delete();
        last_sum = 1'b0;
        last_carry = 1'b0;
`ifdef HALF_ADDER_STATS_EN
        exp_op = 0;
        exp_cr = 0;
`endif
    endtask

    initial begin
        // Asynchronous reset with the clock stopped.
        #1 rst_n = 1'b0;
        #1;
        reset_model();
        check("rst_sum_q", {31'd0, sum_q}, 32'd0);
        check("rst_carry_q", {31'd0, carry_q}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef HALF_ADDER_STATS_EN
        check("rst_op_cnt", {30'd0, op_cnt}, 32'd0);
        check("rst_carry_cnt", {30'd0, carry_cnt}, 32'd0);
`endif

        // Combinational truth table, clock idle, 20 ns per pair.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] p;
            p = 2'(i);
            a = p[1];
            b = p[0];
            #10;
            check("idle_sum", {31'd0, sum}, {31'd0, p[1] ^ p[0]});
            check("idle_carry", {31'd0, carry}, {31'd0, p[1] & p[0]});
            #10;
            check("idle_sum_late", {31'd0, sum}, {31'd0, p[1] ^ p[0]});
        end

        // Pair offered while in reset is accepted on the first edge after release.
        clk_en = 1'b1;
        drive(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        settle();

        // Single 11 pair, then an idle cycle that must hold the result.
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // All four pairs back to back.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);

        // Reset between edges while out_valid is high.
        step(1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        reset_model();
        check("async_sum_q", {31'd0, sum_q}, 32'd0);
        check("async_carry_q", {31'd0, carry_q}, 32'd0);
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_comb_sum", {31'd0, sum}, 32'd1);
        in_valid = 1'b0;
        cur_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

`ifdef HALF_ADDER_STATS_EN
        // Saturation and clear-priority for the statistics counters.
        cnt_clr = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        cnt_clr = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        cnt_clr = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
        check("sat_op_cnt", {30'd0, op_cnt}, 32'd3);
        check("sat_carry_cnt", {30'd0, carry_cnt}, 32'd3);
        cnt_clr = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        cnt_clr = 1'b0;
        check("clr_op_cnt", {30'd0, op_cnt}, 32'd0);
        check("clr_carry_cnt", {30'd0, carry_cnt}, 32'd0);
`endif

        check("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter CNT_W, default 16, width of the statistics counters (legal range 1..32).
REQ-002 clk  input  1  rising-edge clock for all registered logic.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 a  input  1  addend bit A.
REQ-005 b  input  1  addend bit B.
REQ-006 in_valid  input  1  qualifies a/b for capture into the registered path.
REQ-007 sum  output  1  combinational sum, a XOR b.
REQ-008 carry  output  1  combinational carry, a AND b.
REQ-009 sum_q  output  1  registered sum of the last accepted operand pair.
REQ-010 carry_q  output  1  registered carry of the last accepted operand pair.
REQ-011 out_valid  output  1  high for one cycle after each accepted operand pair.
REQ-012 cnt_clr  input  1  synchronous clear of the statistics counters (present only with HALF_ADDER_STATS_EN).
REQ-013 op_cnt  output  CNT_W  count of accepted operand pairs (present only with HALF_ADDER_STATS_EN).
REQ-014 carry_cnt  output  CNT_W  count of accepted pairs with carry=1 (present only with HALF_ADDER_STATS_EN).

Function
REQ-015 sum and carry SHALL be purely combinational from a and b, zero latency, independent of clk, rst_n and in_valid.
REQ-016 sum and carry SHALL be correct with clk idle and rst_n undriven or held at any level.
REQ-017 Truth table SHALL be: 00->sum0 carry0, 01->sum1 carry0, 10->sum1 carry0, 11->sum0 carry1.
REQ-018 On a rising clk edge with in_valid=1, sum_q and carry_q SHALL load a XOR b and a AND b (latency 1 cycle).
REQ-019 On a rising clk edge with in_valid=0, sum_q and carry_q SHALL hold their previous values.
REQ-020 out_valid SHALL equal in_valid registered by one clock edge; back-to-back in_valid SHALL produce back-to-back out_valid.
REQ-021 sum_q and carry_q SHALL never both be 1.
REQ-022 There is no backpressure; every cycle with in_valid=1 SHALL be accepted.

Reset
REQ-023 rst_n=0 SHALL asynchronously force sum_q=0, carry_q=0, out_valid=0 and, when compiled in, op_cnt=0 and carry_cnt=0.
REQ-024 Reset release SHALL take effect at the first rising clk edge with rst_n=1; an in_valid present on that edge SHALL be accepted.
REQ-025 Reset asserted mid-stream SHALL discard any pending out_valid; the combinational sum/carry SHALL be unaffected.

Configuration
REQ-026 With macro HALF_ADDER_STATS_EN defined, cnt_clr, op_cnt and carry_cnt SHALL exist; without it, those ports and their logic SHALL be absent and all other behaviour SHALL be identical.
REQ-027 op_cnt SHALL increment by 1 per accepted pair; carry_cnt SHALL increment by 1 per accepted pair with a=1 and b=1.
REQ-028 Both counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-029 cnt_clr=1 SHALL zero both counters on the next rising edge, taking priority over a simultaneous increment.

Verification
REQ-030 Drive a/b = 00, 01, 10, 11, 20 ns each, clock idle -> sum = 0,1,1,0 and carry = 0,0,0,1 within each interval.
REQ-031 Reset, then in_valid=1 with a=1,b=1 for one cycle -> next cycle sum_q=0, carry_q=1, out_valid=1; following cycle out_valid=0, sum_q/carry_q held.
REQ-032 Stream all four pairs back-to-back with in_valid=1 -> out_valid high four consecutive cycles, sum_q = 0,1,1,0 one cycle behind inputs.
REQ-033 Assert rst_n=0 between clock edges while out_valid=1 -> sum_q, carry_q, out_valid go 0 immediately, without a clock edge.
REQ-034 With HALF_ADDER_STATS_EN, CNT_W=2, apply 5 accepted 11 pairs -> op_cnt=3, carry_cnt=3 (saturated); then cnt_clr=1 together with in_valid=1 -> both 0.
REQ-035 Without HALF_ADDER_STATS_EN, rerun REQ-030..REQ-033 -> identical results.
